// File: rtl/bandit_egreedy.sv
// Epsilon-greedy multi-armed bandit: per-arm EMA value table, argmax scan,
// LFSR-driven exploration, with action and reward valid/ready channels.
module bandit_egreedy #(
  parameter int          ARMS          = 256,
  parameter int          ACTION_WIDTH  = $clog2(ARMS),
  parameter int          REWARD_WIDTH  = 16,
  parameter int          RATE_SHIFT    = 3,
  parameter int          EPSILON_WIDTH = 8,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_0001
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [EPSILON_WIDTH-1:0] epsilon,
  input  logic                     reward_valid,
  input  logic [REWARD_WIDTH-1:0]  reward_data,
  output logic                     reward_ready,
  output logic                     action_valid,
  output logic [ACTION_WIDTH-1:0]  action_data,
  output logic                     action_explore,
  input  logic                     action_ready
);

  typedef enum logic [2:0] {
    S_CLEAR, S_SCAN, S_DECIDE, S_OFFER, S_AWAIT, S_UPDATE
  } state_t;

  localparam logic [ACTION_WIDTH-1:0] LAST_IDX  = ACTION_WIDTH'(ARMS - 1);
  localparam logic [31:0]             LFSR_MASK = 32'h8020_0003;

  state_t                     state, state_nxt;
  logic [ACTION_WIDTH-1:0]    idx;
  logic                       upd_ph;
  logic [31:0]                lfsr, lfsr_adv;
  logic [REWARD_WIDTH-1:0]    best_val;
  logic [ACTION_WIDTH-1:0]    best_idx, greedy_idx;
  logic [EPSILON_WIDTH-1:0]   rnd;
  logic                       explore;

  logic [REWARD_WIDTH-1:0]    mem [ARMS];
  logic                       mem_we;
  logic [ACTION_WIDTH-1:0]    mem_addr;
  logic [REWARD_WIDTH-1:0]    mem_wdata;

  logic [REWARD_WIDTH-1:0]    reward_p0;
  logic [REWARD_WIDTH-1:0]    rd_data_p1;
  logic [ACTION_WIDTH-1:0]    idx_p1;
  logic                       vld_p1;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Arithmetic shift floors the step; the result stays between v and r.
  function automatic logic [REWARD_WIDTH-1:0] ema_update(
    input logic [REWARD_WIDTH-1:0] v,
    input logic [REWARD_WIDTH-1:0] r
  );
    logic signed [REWARD_WIDTH:0] diff, step, sum;
    diff = $signed({1'b0, r}) - $signed({1'b0, v});
    step = diff >>> RATE_SHIFT;
    sum  = $signed({1'b0, v}) + step;
    return REWARD_WIDTH'(sum);
  endfunction

  always_comb begin
    lfsr_adv   = lfsr_step(lfsr);
    rnd        = lfsr_adv[31 -: EPSILON_WIDTH];
    explore    = (rnd < epsilon);
    greedy_idx = (vld_p1 && (rd_data_p1 > best_val)) ? idx_p1 : best_idx;
    mem_we     = (state == S_CLEAR) || ((state == S_UPDATE) && upd_ph);
    mem_addr   = (state == S_UPDATE) ? action_data : idx;
    mem_wdata  = (state == S_CLEAR) ? '0 : ema_update(rd_data_p1, reward_p0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:  if (idx == LAST_IDX) state_nxt = S_SCAN;
      S_SCAN:   if (idx == LAST_IDX) state_nxt = S_DECIDE;
      S_DECIDE: state_nxt = S_OFFER;
      S_OFFER:  if (action_ready) state_nxt = S_AWAIT;
      S_AWAIT:  if (reward_valid && reward_ready) state_nxt = S_UPDATE;
      S_UPDATE: if (upd_ph) state_nxt = S_SCAN;
      default:  state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_CLEAR;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx            <= '0;
      upd_ph         <= 1'b0;
      lfsr           <= LFSR_SEED;
      best_val       <= '0;
      best_idx       <= '0;
      vld_p1         <= 1'b0;
      action_valid   <= 1'b0;
      action_data    <= '0;
      action_explore <= 1'b0;
      reward_ready   <= 1'b0;
    end else begin
      vld_p1 <= (state == S_SCAN);
      case (state)
        S_CLEAR: idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        S_SCAN: begin
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          if (idx == '0) begin
            best_val <= '0;
            best_idx <= '0;
          end else if (vld_p1 && (rd_data_p1 > best_val)) begin
            best_val <= rd_data_p1;
            best_idx <= idx_p1;
          end
        end
        // The last scanned entry is still in flight, so it is folded in here.
        S_DECIDE: begin
          lfsr           <= lfsr_adv;
          best_idx       <= greedy_idx;
          action_valid   <= 1'b1;
          action_explore <= explore;
          action_data    <= explore ? lfsr_adv[ACTION_WIDTH-1:0] : greedy_idx;
        end
        S_OFFER: begin
          if (action_ready) begin
            action_valid <= 1'b0;
            reward_ready <= 1'b1;
          end
        end
        S_AWAIT: if (reward_valid && reward_ready) reward_ready <= 1'b0;
        S_UPDATE: upd_ph <= ~upd_ph;
        default: ;
      endcase
    end
  end

  // Stage p1: synchronous table read; the address index travels alongside.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else        rd_data_p1    <= mem[mem_addr];
    idx_p1 <= idx;
    if ((state == S_AWAIT) && reward_valid && reward_ready) reward_p0 <= reward_data;
  end

endmodule

// File: doc/bandit_egreedy.md
Name: bandit_egreedy

Overview:
- Parametrised successor to the greedy action selector: an epsilon-greedy multi-armed bandit agent with a configurable arm count, reward width, learning rate and runtime exploration probability.
- Keeps one value estimate per arm and offers one action per round on a valid/ready stream.
- Accepts one reward per round on a second valid/ready stream and updates that arm's estimate as an exponential moving average.
- Sits between the environment and the reward source in the learning datapath.

Parameters:
- ARMS, 256, number of arms; power of two, range 2..1024.
- ACTION_WIDTH, $clog2(ARMS), width of action_data.
- REWARD_WIDTH, 16, unsigned reward and value width.
- RATE_SHIFT, 3, learning rate is 2^-RATE_SHIFT; range 0..REWARD_WIDTH-1.
- EPSILON_WIDTH, 8, width of the epsilon input.
- LFSR_SEED, 32'hACE1_0001, nonzero seed for the 32-bit Galois LFSR (taps 32,22,2,1).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- epsilon  in  EPSILON_WIDTH  explore if rand < epsilon; sampled in DECIDE.
- reward_valid  in  1  reward offered.
- reward_data  in  REWARD_WIDTH  unsigned reward for the current action.
- reward_ready  out  1  high only in AWAIT.
- action_valid  out  1  action offered.
- action_data  out  ACTION_WIDTH  chosen arm.
- action_explore  out  1  qualifies action_data: 1 = random arm, 0 = greedy arm.
- action_ready  in  1  consumer accepts action.

Behaviour:
- Reset (reset_n low at a clock edge, any state):
  - FSM goes to CLEAR; scan index = 0.
  - action_valid = 0, action_data = 0, action_explore = 0, reward_ready = 0.
  - LFSR = LFSR_SEED; best value = 0; best index = 0.
- FSM states: CLEAR, SCAN, DECIDE, OFFER, AWAIT, UPDATE.
- CLEAR:
  - Writes 0 to table[index] each cycle, ARMS cycles.
  - Goes to SCAN at index wrap (ARMS-1 -> 0).
- SCAN:
  - Reads one entry per cycle, ARMS cycles, indices 0..ARMS-1.
  - Best value and best index are cleared on entry.
  - Update best only when the entry is strictly greater, so ties resolve to the lowest index.
  - Goes to DECIDE after index ARMS-1 has been compared.
- DECIDE (1 cycle):
  - Advance the LFSR once.
  - r = lfsr[31 -: EPSILON_WIDTH]; a = lfsr[ACTION_WIDTH-1:0].
  - If r < epsilon: action_data = a, action_explore = 1.
  - Else: action_data = best index, action_explore = 0.
  - action_valid <= 1; go to OFFER.
  - epsilon = 0 gives pure greedy; epsilon = all-ones explores with probability (2^W-1)/2^W.
- OFFER:
  - action_valid, action_data and action_explore are held stable until action_ready is sampled high.
  - On handshake: action_valid <= 0, reward_ready <= 1, go to AWAIT.
- AWAIT:
  - Waits indefinitely.
  - On reward_valid & reward_ready: capture reward_data, reward_ready <= 0, go to UPDATE.
  - action_valid stays 0 throughout.
- UPDATE (2 cycles):
  - Cycle 1 reads v = table[action_data].
  - Cycle 2 writes v' = v + ((r - v) >>> RATE_SHIFT).
  - The difference is signed REWARD_WIDTH+1 bits; the shift is arithmetic (rounds toward minus infinity).
  - v' always lies within [min(v,r), max(v,r)], so no saturation is needed; the result is truncated to REWARD_WIDTH.
  - Then go to SCAN.
- Latency:
  - First action_valid rises 2*ARMS+1 cycles after the first edge with reset_n high.
  - From reward handshake to next action_valid: 2 + ARMS + 1 cycles.
- Channel ordering: the action and reward channels are never ready or valid simultaneously from the block's side. A reward presented outside AWAIT is ignored; it is not queued.
- Storage: table is a single-port synchronous RAM of ARMS x REWARD_WIDTH; one access per cycle.
- Reset mid-operation (e.g. in OFFER or AWAIT) discards the pending round, re-clears the table and reseeds the LFSR.

Test Plan:
- Reset, epsilon=0, ARMS=8, action_ready=1 -> action_valid rises 17 cycles after reset release; action_data=0, action_explore=0.
- epsilon=0; action 0 accepted; reward 800 -> table[0]=100; next action 0. Then reward 0 -> table[0]=87, since (-100)>>>3 = -13.
- epsilon=0; rewards make arms 3 and 5 both equal 50 with others 0 -> greedy action is 3 (lowest index wins ties).
- action_ready held low 20 cycles -> action_valid, action_data and action_explore stable throughout; reward_ready stays 0. A reward_valid pulse during this window is ignored and the table is unchanged.
- epsilon=all-ones, 1000 rounds -> action_explore=1 in at least 990 rounds and every arm is chosen. epsilon=0 -> action_explore never 1. The action sequence matches a reference LFSR model from LFSR_SEED.
- reset_n low for 1 cycle while in AWAIT -> reward_ready=0 next cycle; table reads all zero after CLEAR; first post-reset action identical to the power-on case.
